// File: rtl/berger_zero_stream_encoder.sv
// Berger-zero SEC stream encoder: 8-bit words in, 12-bit codewords out through a
// 2-entry FIFO, tagged with a wrapping write address, with one-shot fault injection.
module berger_zero_stream_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [11:0]       out_code,
  output logic [ADDR_W-1:0] out_addr,
  input  logic              addr_clr,
  input  logic              inj_arm,
  input  logic [11:0]       inj_mask,
  output logic              inj_pending,
  output logic [15:0]       words_out
);

  // Parity bits sit at positions 0,1,3,7 so a single flip of bit k yields syndrome k+1.
  function automatic logic [11:0] encode(input logic [7:0] d);
    logic [11:0] c;
    c[2]  = d[0];
    c[4]  = d[1];
    c[5]  = d[2];
    c[6]  = d[3];
    c[8]  = d[4];
    c[9]  = d[5];
    c[10] = d[6];
    c[11] = d[7];
    c[0]  = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
    c[1]  = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
    c[3]  = d[1] ^ d[2] ^ d[3] ^ d[7];
    c[7]  = d[4] ^ d[5] ^ d[6] ^ d[7];
    return c;
  endfunction

  logic [11:0]       mem_code_q [2];
  logic [ADDR_W-1:0] mem_addr_q [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              inj_pending_q, inj_pending_d;
  logic [11:0]       inj_mask_q, inj_mask_d;
  logic [15:0]       words_q, words_d;

  logic              push, pop;
  logic [11:0]       push_code;

  assign in_ready    = (count_q != 2'd2);
  assign out_valid   = (count_q != 2'd0);
  assign out_code    = mem_code_q[rd_ptr_q];
  assign out_addr    = mem_addr_q[rd_ptr_q];
  assign inj_pending = inj_pending_q;
  assign words_out   = words_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    push_code     = encode(in_data) ^ (inj_pending_q ? inj_mask_q : 12'h000);
    wr_ptr_d      = push ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d      = pop ? ~rd_ptr_q : rd_ptr_q;
    count_d       = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    // A clear wins over the increment; the accepted word still carries addr_q.
    if (addr_clr)  addr_d = '0;
    else if (push) addr_d = addr_q + 1'b1;
    else           addr_d = addr_q;
    // Arming in the same cycle as an accept leaves the new mask pending for the next word.
    inj_mask_d    = inj_mask_q;
    inj_pending_d = inj_pending_q;
    if (inj_arm) begin
      inj_mask_d    = inj_mask;
      inj_pending_d = 1'b1;
    end else if (push) begin
      inj_pending_d = 1'b0;
    end
    words_d = pop ? words_q + 16'd1 : words_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_code_q[0] <= '0;
      mem_code_q[1] <= '0;
      mem_addr_q[0] <= '0;
      mem_addr_q[1] <= '0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      count_q       <= 2'd0;
      addr_q        <= '0;
      inj_pending_q <= 1'b0;
      inj_mask_q    <= '0;
      words_q       <= '0;
    end else begin
      if (push) begin
        mem_code_q[wr_ptr_q] <= push_code;
        mem_addr_q[wr_ptr_q] <= addr_q;
      end
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      addr_q        <= addr_d;
      inj_pending_q <= inj_pending_d;
      inj_mask_q    <= inj_mask_d;
      words_q       <= words_d;
    end
  end

endmodule

// File: tb/tb_berger_zero_stream_encoder.sv
// Directed bench for berger_zero_stream_encoder; expected codewords computed by hand.
module tb_berger_zero_stream_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'h00;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [11:0] out_code;
  logic [7:0]  out_addr;
  logic        addr_clr = 1'b0;
  logic        inj_arm = 1'b0;
  logic [11:0] inj_mask = 12'h000;
  logic        inj_pending;
  logic [15:0] words_out;

  int n_checks = 0;
  int n_fail   = 0;

  berger_zero_stream_encoder #(.ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code), .out_addr(out_addr),
    .addr_clr(addr_clr), .inj_arm(inj_arm), .inj_mask(inj_mask),
    .inj_pending(inj_pending), .words_out(words_out)
  );

  always #5 clk = ~clk;

  // Advance past one rising edge; outputs are then settled for sampling.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
    n_checks++; if (out_code !== 12'h000) begin n_fail++; $display("FAIL reset_out_code got %h exp 000", out_code); end
    n_checks++; if (out_addr !== 8'h00) begin n_fail++; $display("FAIL reset_out_addr got %0d exp 0", out_addr); end
    n_checks++; if (inj_pending !== 1'b0) begin n_fail++; $display("FAIL reset_inj_pending got %0b exp 0", inj_pending); end
    n_checks++; if (words_out !== 16'd0) begin n_fail++; $display("FAIL reset_words_out got %0d exp 0", words_out); end
  endtask

  task automatic test_stream();
    logic [7:0]  dv [4];
    logic [11:0] cv [4];
    dv = '{8'h00, 8'h01, 8'hA5, 8'hFF};
    cv = '{12'h000, 12'h007, 12'hA27, 12'hF77};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = dv[i];
      cycle();
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d] got %0b exp 1", i, out_valid); end
      n_checks++; if (out_code !== cv[i]) begin n_fail++; $display("FAIL stream_code[%0d] got %h exp %h", i, out_code, cv[i]); end
      n_checks++; if (out_addr !== 8'(i)) begin n_fail++; $display("FAIL stream_addr[%0d] got %0d exp %0d", i, out_addr, i); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready[%0d] got %0b exp 1", i, in_ready); end
    end
    in_valid = 1'b0;
    cycle();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drained got %0b exp 0", out_valid); end
    n_checks++; if (words_out !== 16'd4) begin n_fail++; $display("FAIL stream_words_out got %0d exp 4", words_out); end
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h11;
    cycle();
    in_data = 8'h22;
    cycle();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_in_ready got %0b exp 0", in_ready); end
    in_data = 8'h33;
    cycle();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_still_full got %0b exp 0", in_ready); end
    n_checks++; if (out_code !== 12'h186) begin n_fail++; $display("FAIL bp_head_code got %h exp 186", out_code); end
    n_checks++; if (out_addr !== 8'd4) begin n_fail++; $display("FAIL bp_head_addr got %0d exp 4", out_addr); end
    cycle();
    n_checks++; if (out_code !== 12'h186) begin n_fail++; $display("FAIL bp_stable_code got %h exp 186", out_code); end
    out_ready = 1'b1;
    cycle();
    n_checks++; if (out_code !== 12'h29B) begin n_fail++; $display("FAIL bp_second_code got %h exp 29b", out_code); end
    n_checks++; if (out_addr !== 8'd5) begin n_fail++; $display("FAIL bp_second_addr got %0d exp 5", out_addr); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_pop got %0b exp 1", in_ready); end
    cycle();
    in_valid = 1'b0;
    n_checks++; if (out_code !== 12'h31D) begin n_fail++; $display("FAIL bp_third_code got %h exp 31d", out_code); end
    n_checks++; if (out_addr !== 8'd6) begin n_fail++; $display("FAIL bp_third_addr got %0d exp 6", out_addr); end
    cycle();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained got %0b exp 0", out_valid); end
    n_checks++; if (words_out !== 16'd7) begin n_fail++; $display("FAIL bp_words_out got %0d exp 7", words_out); end
  endtask

  task automatic test_inject();
    out_ready = 1'b1;
    inj_arm   = 1'b1;
    inj_mask  = 12'h010;
    cycle();
    inj_arm  = 1'b0;
    inj_mask = 12'h000;
    n_checks++; if (inj_pending !== 1'b1) begin n_fail++; $display("FAIL inj_pending_set got %0b exp 1", inj_pending); end
    in_valid = 1'b1;
    in_data  = 8'hA5;
    cycle();
    n_checks++; if (out_code !== 12'hA37) begin n_fail++; $display("FAIL inj_flipped_code got %h exp a37", out_code); end
    n_checks++; if (out_addr !== 8'd7) begin n_fail++; $display("FAIL inj_flipped_addr got %0d exp 7", out_addr); end
    n_checks++; if (inj_pending !== 1'b0) begin n_fail++; $display("FAIL inj_pending_clear got %0b exp 0", inj_pending); end
    cycle();
    in_valid = 1'b0;
    n_checks++; if (out_code !== 12'hA27) begin n_fail++; $display("FAIL inj_clean_code got %h exp a27", out_code); end
    cycle();
  endtask

  task automatic test_arm_same_cycle();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'hFF;
    inj_arm   = 1'b1;
    inj_mask  = 12'h800;
    cycle();
    inj_arm = 1'b0;
    in_data = 8'h00;
    n_checks++; if (out_code !== 12'hF77) begin n_fail++; $display("FAIL arm_same_code got %h exp f77", out_code); end
    n_checks++; if (out_addr !== 8'd9) begin n_fail++; $display("FAIL arm_same_addr got %0d exp 9", out_addr); end
    n_checks++; if (inj_pending !== 1'b1) begin n_fail++; $display("FAIL arm_same_pending got %0b exp 1", inj_pending); end
    cycle();
    in_valid = 1'b0;
    n_checks++; if (out_code !== 12'h800) begin n_fail++; $display("FAIL arm_next_code got %h exp 800", out_code); end
    n_checks++; if (inj_pending !== 1'b0) begin n_fail++; $display("FAIL arm_next_pending got %0b exp 0", inj_pending); end
    cycle();
    n_checks++; if (words_out !== 16'd11) begin n_fail++; $display("FAIL arm_words_out got %0d exp 11", words_out); end
  endtask

  task automatic test_addr_wrap_and_clear();
    logic [7:0] ea;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h00;
    for (int i = 11; i <= 260; i++) begin
      cycle();
      ea = i[7:0];
      n_checks++; if (out_addr !== ea) begin n_fail++; $display("FAIL wrap_addr[%0d] got %0d exp %0d", i, out_addr, ea); end
    end
    addr_clr = 1'b1;
    cycle();
    addr_clr = 1'b0;
    n_checks++; if (out_addr !== 8'd5) begin n_fail++; $display("FAIL clr_same_addr got %0d exp 5", out_addr); end
    cycle();
    in_valid = 1'b0;
    n_checks++; if (out_addr !== 8'd0) begin n_fail++; $display("FAIL clr_next_addr got %0d exp 0", out_addr); end
    cycle();
    n_checks++; if (words_out !== 16'd263) begin n_fail++; $display("FAIL wrap_words_out got %0d exp 263", words_out); end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h11;
    cycle();
    in_data = 8'h22;
    inj_arm = 1'b1;
    inj_mask = 12'h003;
    cycle();
    inj_arm  = 1'b0;
    in_valid = 1'b0;
    n_checks++; if (inj_pending !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_setup got pending=%0b ready=%0b exp 1/0", inj_pending, in_ready); end
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid got %0b exp 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready got %0b exp 1", in_ready); end
    n_checks++; if (out_code !== 12'h000) begin n_fail++; $display("FAIL mid_out_code got %h exp 000", out_code); end
    n_checks++; if (out_addr !== 8'd0) begin n_fail++; $display("FAIL mid_out_addr got %0d exp 0", out_addr); end
    n_checks++; if (inj_pending !== 1'b0) begin n_fail++; $display("FAIL mid_inj_pending got %0b exp 0", inj_pending); end
    n_checks++; if (words_out !== 16'd0) begin n_fail++; $display("FAIL mid_words_out got %0d exp 0", words_out); end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'hA5;
    cycle();
    in_valid = 1'b0;
    n_checks++; if (out_code !== 12'hA27) begin n_fail++; $display("FAIL mid_first_code got %h exp a27", out_code); end
    n_checks++; if (out_addr !== 8'd0) begin n_fail++; $display("FAIL mid_first_addr got %0d exp 0", out_addr); end
    cycle();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_back_pressure();
    test_inject();
    test_arm_same_cycle();
    test_addr_wrap_and_clear();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/berger_zero_stream_encoder.md
# berger_zero_stream_encoder

Write-side companion of the Berger-zero SEC decoder. It accepts 8-bit data words over a valid/ready stream and produces the 12-bit single-error-correcting codeword that the decoder expects, tagged with a wrapping write address for memory. The output passes through a 2-entry buffer. A one-shot fault-injection path flips chosen codeword bits so that the decoder's correction path can be exercised in-system.

## Interface
- ADDR_W, 8, width of the write-address counter
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  upstream word valid
- in_ready  out  1  encoder can accept a word
- in_data  in  8  data word
- out_valid  out  1  codeword available
- out_ready  in  1  downstream accepts codeword
- out_code  out  12  encoded word (with injection applied)
- out_addr  out  ADDR_W  write address tagged to out_code
- addr_clr  in  1  reset the address counter to 0
- inj_arm  in  1  pulse: latch inj_mask for the next accepted word
- inj_mask  in  12  bit-flip mask, XORed into the codeword
- inj_pending  out  1  mask armed and not yet consumed
- words_out  out  16  count of completed output transfers, wraps

## Operation
- Codeword layout (d = in_data, c = code):
  - Data bits: c2=d0, c4=d1, c5=d2, c6=d3, c8=d4, c9=d5, c10=d6, c11=d7.
  - Parity bits: c0=d0^d1^d3^d4^d6, c1=d0^d2^d3^d5^d6, c3=d1^d2^d3^d7, c7=d4^d5^d6^d7.
  - A clean codeword gives decoder syndrome 0. Flipping bit k gives syndrome k+1.
- Input accept = in_valid & in_ready. Output transfer = out_valid & out_ready.
- On accept:
  - The clean code is XORed with the latched mask if inj_pending=1; otherwise the code is written unmodified.
  - The result and the current address counter are pushed into the buffer.
  - The address counter increments mod 2^ADDR_W.
- Buffer:
  - 2-entry FIFO, in order.
  - in_ready = (occupancy != 2). It depends only on occupancy, with no combinational path from out_ready.
  - out_valid = (occupancy != 0).
  - out_code and out_addr present the head entry and must stay stable while out_valid=1 and out_ready=0.
  - Push and pop in the same cycle leave occupancy unchanged.
- Injection:
  - inj_arm=1 latches inj_mask and sets inj_pending, overwriting any pending mask.
  - An accept while inj_pending=1 consumes the mask and clears inj_pending.
  - inj_arm in the same cycle as an accept: the accepted word uses the old state (old mask if one was pending, otherwise clean). The new mask stays pending for the next word.
  - A mask of 0 is legal and consumes the pending state.
- addr_clr:
  - The counter goes to 0 next cycle.
  - A word accepted in the same cycle keeps the pre-clear address, and the counter still goes to 0, not 1.
  - Entries already in the buffer keep their addresses.
- words_out increments on each output transfer and wraps 0xFFFF→0.

## Timing
- Reset (rst_n=0 at a clk edge): buffer empty, out_valid=0, in_ready=1, out_code=0, out_addr=0, address counter=0, inj_pending=0, mask=0, words_out=0.
- A reset asserted mid-stream discards buffered words and any pending mask.
- Latency: a word accepted at edge N is presented on out_code with out_valid=1 after edge N, meaning it is visible in the cycle following acceptance.
- Throughput:
  - With out_ready held at 1, one word per cycle sustained; in_ready never drops.
  - With out_ready=0, at most two words are accepted, then in_ready=0 until a pop.
  - After a pop from full, in_ready returns to 1 in the following cycle.
- inj_pending rises the cycle after inj_arm and falls the cycle after the consuming accept.

## Test plan
- Reset, then stream 0x00, 0x01, 0xA5, 0xFF with out_ready=1 → out_code 0x000, 0x007, 0xA27, 0xF77 at out_addr 0, 1, 2, 3, one per cycle, one cycle after accept. words_out=4.
- Hold out_ready=0 and offer 3 words → two accepted, in_ready=0. Raise out_ready → words drain in order with stable out_code during the stall, and the third word is accepted after the first pop.
- inj_arm with mask 0x010, then send 0xA5 then 0xA5 → first code 0xA37 (decoder syndrome 5), second 0xA27. inj_pending is 1 between arm and consume.
- inj_arm with mask 0x800 in the same cycle as accepting 0xFF, then accept 0x00 → 0xF77 clean, then 0x800.
- Accept words up to address 2^ADDR_W−1 → the next word gets address 0. Then assert addr_clr together with an accept at address 5 → that word carries 5 and the next word carries 0.
- Assert rst_n=0 with the buffer full and a mask pending → all outputs return to their reset values next cycle, and the next word is at address 0 and clean.
